snake_mover: RTL and testbench

SNAKE_MOVER -- requirements
Module: snake_mover

---
 rtl/snake_pkg.sv | 28 ++
 rtl/snake_body.sv | 58 +++++
 rtl/snake_mover.sv | 141 ++++++++++++++
 tb/tb_snake_mover.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types for the snake game: FSM states, move directions and coordinate widths.
package snake_pkg;

    localparam int X_W   = 6;
    localparam int Y_W   = 5;
    localparam int LEN_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_CALC,
        ST_MOVE,
        ST_OVER
    } state_t;

    // Opposite directions share bit 1 and differ in bit 0.
    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    function automatic logic is_reverse(input dir_t a, input dir_t b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

endpackage

// File: rtl/snake_body.sv
// Segment store for the snake: shift register of cells, self-collision compare and renderer probe.
module snake_body
    import snake_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int START_X = 20,
    parameter int START_Y = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_shift,
    input  logic [X_W-1:0]   i_new_x,
    input  logic [Y_W-1:0]   i_new_y,
    input  logic [LEN_W-1:0] i_length,
    input  logic             i_grow_pend,
    input  logic [X_W-1:0]   i_query_x,
    input  logic [Y_W-1:0]   i_query_y,
    output logic             o_occupied,
    output logic             o_hit,
    output logic [X_W-1:0]   o_head_x,
    output logic [Y_W-1:0]   o_head_y
);

    logic [X_W-1:0] r_seg_x [MAX_LEN];
    logic [Y_W-1:0] r_seg_y [MAX_LEN];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= (i == 0) ? X_W'(START_X) : '0;
                r_seg_y[i] <= (i == 0) ? Y_W'(START_Y) : '0;
            end
        end else if (i_shift) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                r_seg_x[i] <= (i == 0) ? i_new_x : r_seg_x[(i == 0) ? 0 : i - 1];
                r_seg_y[i] <= (i == 0) ? i_new_y : r_seg_y[(i == 0) ? 0 : i - 1];
            end
        end
    end

    // The tail cell is free to enter unless growth keeps it in place.
    always_comb begin
        int v_last;
        v_last     = int'(i_length) - (i_grow_pend ? 1 : 2);
        o_hit      = 1'b0;
        o_occupied = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i >= 1 && i <= v_last && r_seg_x[i] == i_new_x && r_seg_y[i] == i_new_y)
                o_hit = 1'b1;
            if (i < int'(i_length) && r_seg_x[i] == i_query_x && r_seg_y[i] == i_query_y)
                o_occupied = 1'b1;
        end
    end

    assign o_head_x = r_seg_x[0];
    assign o_head_y = r_seg_y[0];

endmodule

// File: rtl/snake_mover.sv
// Snake movement controller: direction capture, tick-driven move FSM, bounds/self-collision and growth.
module snake_mover
    import snake_pkg::*;
#(
    parameter int GRID_W  = 40,
    parameter int GRID_H  = 30,
    parameter int MAX_LEN = 16,
    parameter int START_X = 20,
    parameter int START_Y = 15
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             game_tick,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             grow,
    input  logic [X_W-1:0]   query_x,
    input  logic [Y_W-1:0]   query_y,
    output logic             occupied,
    output logic [X_W-1:0]   head_x,
    output logic [Y_W-1:0]   head_y,
    output logic [LEN_W-1:0] length,
    output logic             move_done,
    output logic             game_over
);

    localparam logic signed [X_W:0] STEP_X = (X_W+1)'(1);
    localparam logic signed [Y_W:0] STEP_Y = (Y_W+1)'(1);

    state_t                 r_state, w_state_nxt;
    dir_t                   r_dir, r_pend_dir, w_btn_dir;
    logic                   r_grow;
    logic [LEN_W-1:0]       r_len;
    logic signed [X_W:0]    r_nx, w_cand_x;
    logic signed [Y_W:0]    r_ny, w_cand_y;
    logic                   w_btn_any, w_shift, w_hit, w_oob;

    always_comb begin
        w_btn_any = btn_up | btn_down | btn_left | btn_right;
        w_btn_dir = DIR_RIGHT;
        if (btn_up)         w_btn_dir = DIR_UP;
        else if (btn_down)  w_btn_dir = DIR_DOWN;
        else if (btn_left)  w_btn_dir = DIR_LEFT;
    end

    // Candidate head carries a sign bit so a step off the low edge is visible as negative.
    always_comb begin
        w_cand_x = $signed({1'b0, head_x});
        w_cand_y = $signed({1'b0, head_y});
        case (r_pend_dir)
            DIR_UP:   w_cand_y = w_cand_y - STEP_Y;
            DIR_DOWN: w_cand_y = w_cand_y + STEP_Y;
            DIR_LEFT: w_cand_x = w_cand_x - STEP_X;
            default:  w_cand_x = w_cand_x + STEP_X;
        endcase
    end

    assign w_oob = (int'(r_nx) < 0) || (int'(r_nx) >= GRID_W) ||
                   (int'(r_ny) < 0) || (int'(r_ny) >= GRID_H);

    always_ff @(posedge clk_100MHz) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        case (r_state)
            ST_IDLE: if (w_btn_any) w_state_nxt = ST_RUN;
            ST_RUN:  if (game_tick) w_state_nxt = ST_CALC;
            ST_CALC: w_state_nxt = (w_oob || w_hit) ? ST_OVER : ST_MOVE;
            ST_MOVE: begin
                w_state_nxt = ST_RUN;
                w_shift     = 1'b1;
            end
            ST_OVER: w_state_nxt = ST_OVER;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            r_dir      <= DIR_RIGHT;
            r_pend_dir <= DIR_RIGHT;
            r_grow     <= 1'b0;
            r_len      <= LEN_W'(1);
        end else begin
            case (r_state)
                ST_IDLE: if (w_btn_any) begin
                    r_dir      <= w_btn_dir;
                    r_pend_dir <= w_btn_dir;
                end
                ST_RUN, ST_CALC, ST_MOVE:
                    if (w_btn_any && !is_reverse(w_btn_dir, r_dir)) r_pend_dir <= w_btn_dir;
                default: ;
            endcase
            if (grow && r_state != ST_OVER) r_grow <= 1'b1;
            // A grow pulse landing on the MOVE cycle is folded into this move.
            if (w_shift) begin
                r_dir  <= r_pend_dir;
                r_grow <= 1'b0;
                if ((r_grow || grow) && int'(r_len) < MAX_LEN) r_len <= r_len + LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (r_state == ST_RUN && game_tick) begin
            r_nx <= w_cand_x;
            r_ny <= w_cand_y;
        end
    end

    snake_body #(
        .MAX_LEN (MAX_LEN),
        .START_X (START_X),
        .START_Y (START_Y)
    ) u_body (
        .clk         (clk_100MHz),
        .reset       (reset),
        .i_shift     (w_shift),
        .i_new_x     (r_nx[X_W-1:0]),
        .i_new_y     (r_ny[Y_W-1:0]),
        .i_length    (r_len),
        .i_grow_pend (r_grow),
        .i_query_x   (query_x),
        .i_query_y   (query_y),
        .o_occupied  (occupied),
        .o_hit       (w_hit),
        .o_head_x    (head_x),
        .o_head_y    (head_y)
    );

    assign length    = r_len;
    assign move_done = w_shift;
    assign game_over = (r_state == ST_OVER);

endmodule

// File: tb/tb_snake_mover.sv
// Scoreboard bench for snake_mover: ticks queue expected moves, a monitor checks each move_done.
module tb_snake_mover;

    logic       clk_100MHz = 1'b0;
    logic       reset = 1'b1;
    logic       game_tick = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       grow = 1'b0;
    logic [5:0] query_x = '0;
    logic [4:0] query_y = '0;
    logic       occupied;
    logic [5:0] head_x;
    logic [4:0] head_y;
    logic [4:0] length;
    logic       move_done, game_over;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int x;
        int y;
        int len;
        int cyc;
    } exp_t;
    exp_t sb_q[$];
    exp_t mon_e;

    snake_mover dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .game_tick  (game_tick),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .grow       (grow),
        .query_x    (query_x),
        .query_y    (query_y),
        .occupied   (occupied),
        .head_x     (head_x),
        .head_y     (head_y),
        .length     (length),
        .move_done  (move_done),
        .game_over  (game_over)
    );

    always #5 clk_100MHz = ~clk_100MHz;
    always @(posedge clk_100MHz) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every move_done must match the oldest queued move, 2 cycles after its tick.
    always @(negedge clk_100MHz) begin
        if (move_done === 1'b1) begin
            chk("move_done_expected", int'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("move_done_latency", cyc - mon_e.cyc, 2);
                @(negedge clk_100MHz);
                chk("move_head_x", int'(head_x), mon_e.x);
                chk("move_head_y", int'(head_y), mon_e.y);
                chk("move_length", int'(length), mon_e.len);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk_100MHz) reset = 1'b1;
        @(negedge clk_100MHz);
        @(negedge clk_100MHz) reset = 1'b0;
    endtask

    // mask = {up, down, left, right}
    task automatic press_mask(input logic [3:0] m);
        @(negedge clk_100MHz);
        {btn_up, btn_down, btn_left, btn_right} = m;
        @(negedge clk_100MHz);
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    endtask

    task automatic pulse_grow();
        @(negedge clk_100MHz) grow = 1'b1;
        @(negedge clk_100MHz) grow = 1'b0;
    endtask

    task automatic tick_move(input int x, input int y, input int len, input bit grow_in_move);
        @(negedge clk_100MHz);
        game_tick = 1'b1;
        sb_q.push_back('{x, y, len, cyc});
        @(negedge clk_100MHz) game_tick = 1'b0;
        @(negedge clk_100MHz) grow = grow_in_move;
        @(negedge clk_100MHz) grow = 1'b0;
    endtask

    task automatic tick_ignored();
        @(negedge clk_100MHz) game_tick = 1'b1;
        @(negedge clk_100MHz) game_tick = 1'b0;
        repeat (3) @(negedge clk_100MHz);
    endtask

    task automatic tick_over(input string name, input int x, input int y, input int len);
        @(negedge clk_100MHz) game_tick = 1'b1;
        @(negedge clk_100MHz) game_tick = 1'b0;
        chk({name, "_calc_not_over"}, int'(game_over), 0);
        @(negedge clk_100MHz);
        chk({name, "_over"}, int'(game_over), 1);
        chk({name, "_head_x"}, int'(head_x), x);
        chk({name, "_head_y"}, int'(head_y), y);
        chk({name, "_length"}, int'(length), len);
    endtask

    task automatic probe(input string name, input int x, input int y, input int exp);
        query_x = 6'(x);
        query_y = 5'(y);
        #1;
        chk(name, int'(occupied), exp);
    endtask

    initial begin
        int occ_cnt;

        // Reset state and idle behaviour
        do_reset();
        chk("rst_head_x", int'(head_x), 20);
        chk("rst_head_y", int'(head_y), 15);
        chk("rst_length", int'(length), 1);
        chk("rst_game_over", int'(game_over), 0);
        chk("rst_move_done", int'(move_done), 0);
        probe("rst_occ_head", 20, 15, 1);
        probe("rst_occ_dead_seg", 0, 0, 0);
        tick_ignored();
        chk("idle_tick_head_x", int'(head_x), 20);

        // Three moves right, reversal ignored, grow on the MOVE cycle
        press_mask(4'b0001);
        tick_move(21, 15, 1, 1'b0);
        tick_move(22, 15, 1, 1'b0);
        tick_move(23, 15, 1, 1'b0);
        press_mask(4'b0010);
        tick_move(24, 15, 1, 1'b0);
        chk("reverse_no_over", int'(game_over), 0);
        tick_move(25, 15, 2, 1'b1);
        tick_move(26, 15, 2, 1'b0);

        // Left wall
        do_reset();
        press_mask(4'b0010);
        for (int i = 1; i <= 20; i++) tick_move(20 - i, 15, 1, 1'b0);
        tick_over("wall", 0, 15, 1);
        tick_ignored();
        press_mask(4'b0001);
        pulse_grow();
        chk("over_frozen_x", int'(head_x), 0);
        chk("over_frozen_len", int'(length), 1);
        chk("over_held", int'(game_over), 1);

        // Self collision with a length-5 body
        do_reset();
        press_mask(4'b0001);
        for (int i = 1; i <= 4; i++) begin
            pulse_grow();
            tick_move(20 + i, 15, 1 + i, 1'b0);
        end
        press_mask(4'b1000);
        tick_move(24, 14, 5, 1'b0);
        press_mask(4'b0010);
        tick_move(23, 14, 5, 1'b0);
        press_mask(4'b0100);
        tick_over("self", 23, 14, 5);

        // Entering the vacating tail is legal; with growth pending it is not
        do_reset();
        press_mask(4'b0001);
        for (int i = 1; i <= 3; i++) begin
            pulse_grow();
            tick_move(20 + i, 15, 1 + i, 1'b0);
        end
        press_mask(4'b1000);
        tick_move(23, 14, 4, 1'b0);
        press_mask(4'b0010);
        tick_move(22, 14, 4, 1'b0);
        press_mask(4'b0100);
        tick_move(22, 15, 4, 1'b0);
        chk("tail_vacate_no_over", int'(game_over), 0);
        pulse_grow();
        press_mask(4'b0001);
        tick_over("tail_grow", 22, 15, 4);

        // Growth saturation and occupancy of exactly MAX_LEN cells
        do_reset();
        press_mask(4'b0001);
        for (int i = 1; i <= 20; i++) begin
            if (i == 16) press_mask(4'b1000);
            pulse_grow();
            if (i <= 15) tick_move(20 + i, 15, (i + 1 > 16) ? 16 : i + 1, 1'b0);
            else         tick_move(35, 15 - (i - 15), 16, 1'b0);
        end
        chk("sat_length", int'(length), 16);
        occ_cnt = 0;
        for (int x = 0; x < 40; x++) begin
            for (int y = 0; y < 30; y++) begin
                query_x = 6'(x);
                query_y = 5'(y);
                #1;
                occ_cnt += int'(occupied);
            end
        end
        chk("sat_occ_count", occ_cnt, 16);
        for (int y = 10; y <= 15; y++) probe("sat_occ_col", 35, y, 1);
        for (int x = 25; x <= 34; x++) probe("sat_occ_row", x, 15, 1);
        probe("sat_occ_shifted_out", 24, 15, 0);
        probe("sat_occ_beside_head", 36, 10, 0);

        // Reset while in CALC
        do_reset();
        press_mask(4'b0001);
        tick_move(21, 15, 1, 1'b0);
        @(negedge clk_100MHz) game_tick = 1'b1;
        @(negedge clk_100MHz);
        game_tick = 1'b0;
        reset = 1'b1;
        @(negedge clk_100MHz) reset = 1'b0;
        chk("calc_rst_head_x", int'(head_x), 20);
        chk("calc_rst_head_y", int'(head_y), 15);
        chk("calc_rst_length", int'(length), 1);
        chk("calc_rst_move_done", int'(move_done), 0);
        chk("calc_rst_game_over", int'(game_over), 0);
        tick_ignored();
        chk("calc_rst_idle_x", int'(head_x), 20);

        // Button priority: up over left/right from IDLE, left over right while running
        press_mask(4'b1011);
        tick_move(20, 14, 1, 1'b0);
        press_mask(4'b0011);
        tick_move(19, 14, 1, 1'b0);

        repeat (3) @(negedge clk_100MHz);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
